// File: rtl/uart_tx_fifo_feeder.sv
// Read-side feeder: pulls bytes from the async FIFO read port and hands them to the UART
// transmitter. A byte is popped only after the UART has finished sending it. A missing busy
// acknowledge aborts the attempt without a pop, so the same byte is loaded again later.
module uart_tx_fifo_feeder #(
    parameter int unsigned DW          = 8,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_rd_data,
    output logic             fifo_rd_flag,
    input  logic             tx_busy,
    output logic [DW-1:0]    tx_p_data,
    output logic             tx_data_valid,
    output logic             timeout_err,
    output logic [CNT_W-1:0] tx_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRESENT   = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_POP       = 3'd4;
    localparam logic [2:0] S_SETTLE    = 3'd5;

    // ACK_TIMEOUT is limited to 255, so an 8-bit timer always suffices
    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [7:0]       r_timer;
    logic [DW-1:0]    r_p_data;
    logic             r_valid;
    logic             r_rd_flag;
    logic             r_timeout;
    logic [CNT_W-1:0] r_count;

    logic [2:0]       w_state_d;
    logic [7:0]       w_timer_d;
    logic             w_load;
    logic             w_valid_d;
    logic             w_rd_flag_d;
    logic             w_timeout_d;
    logic [CNT_W-1:0] w_count_d;

    // Next-state decode; strobes are computed one cycle early so every output is a flop
    always_comb begin
        w_state_d   = r_state;
        w_timer_d   = r_timer;
        w_load      = 1'b0;
        w_valid_d   = 1'b0;
        w_rd_flag_d = 1'b0;
        w_timeout_d = 1'b0;
        w_count_d   = r_count;
        case (r_state)
            S_IDLE: begin
                if (enable && !fifo_empty && !tx_busy) begin
                    w_state_d = S_PRESENT;
                    w_load    = 1'b1;
                    w_valid_d = 1'b1;
                end
            end
            S_PRESENT: begin
                w_state_d = S_WAIT_BUSY;
                w_timer_d = '0;
            end
            S_WAIT_BUSY: begin
                // busy takes priority over an expiring timer
                if (tx_busy) begin
                    w_state_d = S_WAIT_DONE;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_d   = S_IDLE;
                    w_timeout_d = 1'b1;
                end else begin
                    w_timer_d = r_timer + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_d   = S_POP;
                    w_rd_flag_d = 1'b1;
                end
            end
            S_POP: begin
                w_state_d = S_SETTLE;
                w_count_d = r_count + CNT_W'(1);
            end
            // one dead cycle so the FIFO empty flag reflects the pop before IDLE samples it
            S_SETTLE: w_state_d = S_IDLE;
            default:  w_state_d = S_IDLE;
        endcase
    end

    // FSM state, acknowledge timer and completed-byte counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_count <= w_count_d;
        end
    end

    // Registered outputs; the data byte is held until the next load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_data  <= '0;
            r_valid   <= 1'b0;
            r_rd_flag <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_load) begin
                r_p_data <= fifo_rd_data;
            end
            r_valid   <= w_valid_d;
            r_rd_flag <= w_rd_flag_d;
            r_timeout <= w_timeout_d;
        end
    end

    assign tx_p_data     = r_p_data;
    assign tx_data_valid = r_valid;
    assign fifo_rd_flag  = r_rd_flag;
    assign timeout_err   = r_timeout;
    assign tx_count      = r_count;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench for uart_tx_fifo_feeder: a queue-based FIFO model and a UART busy model drive the DUT;
// a scoreboard predicts load data, pop/timeout cycles and the byte count from event timing.
module tb_uart_tx_fifo_feeder;

    localparam int DW    = 8;
    localparam int TMO   = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [DW-1:0]    fifo_rd_data = '0;
    logic             tx_busy = 1'b0;
    logic             fifo_rd_flag;
    logic [DW-1:0]    tx_p_data;
    logic             tx_data_valid;
    logic             timeout_err;
    logic [CNT_W-1:0] tx_count;

    uart_tx_fifo_feeder #(
        .DW          (DW),
        .ACK_TIMEOUT (TMO),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_flag  (fifo_rd_flag),
        .tx_busy       (tx_busy),
        .tx_p_data     (tx_p_data),
        .tx_data_valid (tx_data_valid),
        .timeout_err   (timeout_err),
        .tx_count      (tx_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state
    logic [DW-1:0] fifo_q[$];
    int  cyc = 0;
    int  exp_pop = -1;
    int  exp_to = -1;
    int  bs = -1;
    int  be = -1;
    bit  outstanding = 1'b0;
    int  last_pop = -100;
    int  n_load = 0;
    int  n_pop = 0;
    int  n_to = 0;
    int  n_abort = 0;
    int  model_cnt = 0;
    int  ack_cfg = 0;  // 0: busy after 2 for 10, 1: never, 2: random, 3: busy exactly at timeout edge
    bit  force_busy = 1'b0;
    logic q_en = 1'b0;
    logic q_busy = 1'b0;
    logic q_empty = 1'b1;

    // inputs as the DUT saw them on the edge that may have qualified a load
    always @(posedge clk) begin
        q_en    <= enable;
        q_busy  <= tx_busy;
        q_empty <= fifo_empty;
    end

    // Scoreboard, FIFO model and UART busy model
    always @(negedge clk) begin
        int d;
        int h;
        cyc++;
        if (!rst) begin
            if (outstanding) n_abort++;
            outstanding = 1'b0;
            exp_pop     = -1;
            exp_to      = -1;
            bs          = -1;
            be          = -1;
            model_cnt   = 0;
            last_pop    = -100;
        end else begin
            if (tx_data_valid) begin
                n_load++;
                check_eq("load_data", 32'(tx_p_data),
                         (fifo_q.size() > 0) ? 32'(fifo_q[0]) : 32'hFFFF_FFFF);
                check_eq("load_legal", {28'd0, q_en, q_busy, q_empty, outstanding}, 32'h8);
                check_eq("load_gap", 32'(cyc >= last_pop + 3), 32'd1);
                check_eq("cnt_at_load", 32'(tx_count), 32'(model_cnt % (1 << CNT_W)));
                outstanding = 1'b1;
                case (ack_cfg)
                    0: begin d = 2; h = 10; end
                    1: begin d = 0; h = 0; end
                    3: begin d = TMO; h = 3; end
                    default: begin
                        d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
                        h = $urandom_range(1, 12);
                    end
                endcase
                if (d > 0) begin
                    bs = cyc + d;
                    be = bs + h;
                    exp_pop = be + 1;
                    exp_to  = -1;
                end else begin
                    bs = -1;
                    be = -1;
                    exp_pop = -1;
                    exp_to  = cyc + TMO + 1;
                end
            end
            if (fifo_rd_flag || cyc == exp_pop) begin
                check_eq("pop_timing", 32'(fifo_rd_flag), 32'(cyc == exp_pop));
                if (fifo_rd_flag) begin
                    n_pop++;
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                    model_cnt++;
                    last_pop    = cyc;
                    outstanding = 1'b0;
                    exp_pop     = -1;
                end
            end
            if (timeout_err || cyc == exp_to) begin
                check_eq("timeout_timing", 32'(timeout_err), 32'(cyc == exp_to));
                if (timeout_err) begin
                    n_to++;
                    outstanding = 1'b0;
                    exp_to      = -1;
                end
            end
        end
        tx_busy      = force_busy || (rst && bs >= 0 && cyc >= bs && cyc < be);
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? DW'($urandom) : fifo_q[0];
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            step(1);
            if (fifo_q.size() == 0 && !outstanding) break;
        end
        if (k == budget) check_eq("drain_budget", 32'd0, 32'd1);
        step(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, {tx_p_data, 1'b0, tx_data_valid, fifo_rd_flag, timeout_err,
                       4'(tx_count)}, 32'd0);
    endtask

    initial begin
        int base_load;
        int base_pop;
        int k;
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset_outputs");
        step(3);
        check_reset_outputs("reset_hold");
        #1 rst = 1'b1;
        enable = 1'b1;

        // Single byte
        ack_cfg = 0;
        fifo_q.push_back(8'hA5);
        wait_drain(200);
        check_eq("single_pops", 32'(n_pop), 32'd1);
        check_eq("single_count", 32'(tx_count), 32'(model_cnt % (1 << CNT_W)));
        check_eq("single_no_to", 32'(n_to), 32'd0);

        // Burst of four
        for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(i));
        wait_drain(400);
        check_eq("burst_pops", 32'(n_pop), 32'd5);
        check_eq("burst_count", 32'(tx_count), 32'(model_cnt % (1 << CNT_W)));

        // Timeout then retry of the same byte
        ack_cfg = 1;
        fifo_q.push_back(8'h3C);
        for (k = 0; k < 200 && n_to == 0; k++) step(1);
        check_eq("to_seen", 32'(n_to), 32'd1);
        check_eq("to_no_pop", 32'(n_pop), 32'd5);
        ack_cfg = 0;
        wait_drain(200);
        check_eq("to_retry_pop", 32'(n_pop), 32'd6);

        // Busy rising on the last timer cycle wins over the timeout
        ack_cfg = 3;
        fifo_q.push_back(8'hC3);
        wait_drain(200);
        check_eq("edge_no_to", 32'(n_to), 32'd1);
        ack_cfg = 0;

        // Backpressure in IDLE, then enable dropped mid-byte
        force_busy = 1'b1;
        fifo_q.push_back(8'h5A);
        base_load = n_load;
        step(12);
        check_eq("bp_no_load", 32'(n_load), 32'(base_load));
        force_busy = 1'b0;
        for (k = 0; k < 100 && !(tx_busy && outstanding); k++) step(1);
        enable = 1'b0;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        base_pop = n_pop;
        for (k = 0; k < 100 && n_pop == base_pop; k++) step(1);
        step(30);
        check_eq("en_off_loads", 32'(n_load), 32'(base_load + 1));
        check_eq("en_off_pops", 32'(n_pop), 32'(base_pop + 1));
        enable = 1'b1;
        wait_drain(300);

        // Reset in the middle of a byte
        fifo_q.push_back(8'h77);
        for (k = 0; k < 100 && !(tx_busy && outstanding); k++) step(1);
        step(2);
        base_pop = n_pop;
        #1 rst = 1'b0;
        #1 check_reset_outputs("rst_mid_outputs");
        step(3);
        check_eq("rst_mid_no_pop", 32'(n_pop), 32'(base_pop));
        #1 rst = 1'b1;
        wait_drain(200);
        check_eq("rst_resend_count", 32'(tx_count), 32'd1);

        // Counter wrap: 17 bytes after a fresh reset
        #1 rst = 1'b0;
        step(2);
        #1 rst = 1'b1;
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'(8'h80 + i));
        wait_drain(1000);
        check_eq("wrap_model", 32'(model_cnt), 32'd17);
        check_eq("wrap_count", 32'(tx_count), 32'd1);

        // Randomized traffic
        ack_cfg = 2;
        for (int i = 0; i < 24; i++) fifo_q.push_back(DW'($urandom));
        wait_drain(4000);
        check_eq("rand_count", 32'(tx_count), 32'(model_cnt % (1 << CNT_W)));
        check_eq("balance", 32'(n_pop), 32'(n_load - n_to - n_abort));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
- Single-clock read-side consumer of the async FIFO; lives in the FIFO r_clk (UART) domain.
- Pulls bytes from the FIFO read port and hands each one to the UART transmitter via its P_DATA / DATA_VALID / busy handshake.
- Pops the FIFO only after the UART has finished the byte.
- Provides a busy-acknowledge timeout and a transmitted-byte counter for status.

Parameters:
- DW, 8, data width; equals FIFO DW and UART frame width.
- ACK_TIMEOUT, 16, cycles allowed after DATA_VALID for tx_busy to rise; 2..255.
- CNT_W, 16, width of transmitted-byte counter.

Ports:
- clk  in  1  r_clk domain clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  feeder enable; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag, already in clk domain.
- fifo_rd_data  in  DW  FIFO head word (RD), valid while fifo_empty=0.
- fifo_rd_flag  out  1  one-cycle pop strobe to FIFO rd_flag.
- tx_busy  in  1  UART transmitter busy.
- tx_p_data  out  DW  byte presented to UART P_DATA.
- tx_data_valid  out  1  one-cycle load strobe to UART DATA_VALID.
- timeout_err  out  1  one-cycle pulse: UART did not acknowledge.
- tx_count  out  CNT_W  bytes completed (popped), wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, async): state=IDLE; tx_p_data=0, tx_data_valid=0, fifo_rd_flag=0, timeout_err=0, tx_count=0, timer=0.
- All outputs come from registers; no combinational path from any input to any output.
- FSM states: IDLE, PRESENT, WAIT_BUSY, WAIT_DONE, POP, SETTLE.
- IDLE → PRESENT when enable=1 && fifo_empty=0 && tx_busy=0. On that edge, tx_p_data <= fifo_rd_data. Otherwise stay in IDLE.
- PRESENT: tx_data_valid=1 for exactly this one cycle. Next state WAIT_BUSY; timer <= 0.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Else if timer==ACK_TIMEOUT-1 → IDLE with timeout_err=1 for one cycle. No pop; the byte is retried.
  - Else timer++.
- WAIT_DONE: stay while tx_busy=1; tx_busy=0 → POP.
- POP: fifo_rd_flag=1 for exactly one cycle; tx_count <= tx_count+1 (wraps to 0). Next state SETTLE.
- SETTLE: one cycle, no outputs asserted, ignores fifo_empty. This lets the FIFO read pointer and empty flag update after the pop. Next state IDLE.
- Latency: IDLE-qualify edge to tx_data_valid is 1 cycle. tx_busy falling to fifo_rd_flag is 1 cycle.
- Minimum per-byte period = 5 cycles + UART busy duration.
- tx_p_data holds its value from the load edge until the next load; it is unaffected by FIFO changes.
- enable deasserted mid-byte: the current byte completes through POP/SETTLE; no new load starts until enable=1.
- fifo_empty rising outside IDLE: ignored (the data is already latched).
- tx_busy=1 while in IDLE: no load; wait.
- Reset mid-operation: immediate return to IDLE with no pop. The head byte stays in the FIFO and is retransmitted after reset; tx_count is cleared.
- Timeout with tx_busy rising in the same cycle as timer==ACK_TIMEOUT-1: busy wins → WAIT_DONE, no timeout_err.
- fifo_rd_flag is never asserted while fifo_empty was 1 at load time. The count of pops equals the count of loads minus the count of timeouts.

Test Plan:
- Single byte: FIFO head 0xA5, fifo_empty=0, enable=1, UART model raises busy 2 cycles after DATA_VALID and holds it 10 cycles. Expect tx_data_valid for 1 cycle with tx_p_data=0xA5, fifo_rd_flag for 1 cycle exactly 1 cycle after busy falls, tx_count=1, timeout_err never asserted.
- Burst: 4 bytes 0x01..0x04 queued, with the same UART model. Expect 4 loads in order 0x01..0x04, 4 pops, tx_count=4, each load ≥1 cycle after the preceding SETTLE, no duplicate or lost bytes.
- Timeout: UART model never raises busy, head=0x3C. Expect timeout_err pulse 16 cycles after WAIT_BUSY entry, no fifo_rd_flag, then a re-load of 0x3C; tx_count stays 0.
- Enable/backpressure: enable=1 while tx_busy is held at 1 in IDLE → no tx_data_valid. Then drop enable during WAIT_DONE → byte completes (pop, tx_count+1), no further loads while enable=0 even with FIFO non-empty.
- Reset mid-byte: assert rst=0 during WAIT_DONE. Expect all outputs 0 asynchronously and no pop. After release, the same head byte is re-sent and tx_count ends at 1.
- Counter wrap: CNT_W=4, send 17 bytes → tx_count sequence reaches 15, wraps to 0, ends at 1.
